pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised elastic pipeline register and successor to the fixed 32-bit IF/ID latch.
- Carries LANES parallel instruction slots (pc4 + inst each) between any two pipeline stages, using valid/ready handshake instead of a raw stall input.
- One-entry skid buffer keeps in_ready registered (no combinational ready path) at full throughput.
- Adds per-lane valid mask, synchronous flush with bubble insertion, and a saturating stall-cycle counter for performance monitoring.

Parameters:
- XLEN, 32, width of each pc4 and inst field
- LANES, 1, instruction slots per beat (1..4)
- BUBBLE_INST, 32'h0000_0000, encoding driven on out_inst lanes that carry no instruction (NOP)
- CNT_W, 16, width of stall_cnt

Ports:
- clk  in  1  clock, all state updates on rising edge
- clr  in  1  reset, synchronous, active-high
- flush  in  1  discard all held and incoming beats (branch/exception redirect)
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle (registered)
- in_lane  in  LANES  per-lane valid mask of incoming beat
- in_pc4  in  LANES*XLEN  packed pc4, lane 0 in LSBs
- in_inst  in  LANES*XLEN  packed instructions, lane 0 in LSBs
- out_valid  out  1  beat present at output
- out_ready  in  1  downstream accepts the beat
- out_lane  out  LANES  per-lane valid mask of output beat
- out_pc4  out  LANES*XLEN  packed pc4
- out_inst  out  LANES*XLEN  packed instructions
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage:
  - main register (M) drives the outputs.
  - skid register (S) holds one extra beat.
  - Each has a valid bit.
  - State is derived from the valid bits: EMPTY (M=0,S=0), BUSY (M=1,S=0), FULL (M=1,S=1). S=1 with M=0 is illegal.
- Handshakes:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - in_ready = !S.valid, taken directly from a flop.
  - out_valid = M.valid.
- Transitions (when clr=0 and flush=0):
  - EMPTY: on accept, M<=in and go to BUSY.
  - BUSY:
    - accept & drain: M<=in, stay in BUSY.
    - accept & !drain: S<=in, go to FULL.
    - !accept & drain: go to EMPTY.
    - otherwise hold.
  - FULL: in_ready=0.
    - On drain: M<=S and go to BUSY.
    - Otherwise hold. Upstream data is ignored.
- Latency and ordering:
  - One cycle from accept to out_valid in the EMPTY and BUSY-with-drain cases.
  - Sustains 1 beat/cycle while out_ready=1.
  - Beats leave strictly in arrival order; none are lost or duplicated.
- Flush:
  - Asserting flush clears M.valid and S.valid at the next edge, forces out_lane=0, out_inst=BUBBLE_INST on all lanes and out_pc4=0.
  - A beat presented in the flush cycle is dropped, even if accepted.
  - A drain in the flush cycle still counts as delivered downstream.
  - Flush does not affect stall_cnt.
- Reset (clr=1):
  - Overrides flush and everything else, including mid-transfer.
  - Reset values: out_valid=0, in_ready=1 after the edge, out_lane=0, out_pc4=0, out_inst=BUBBLE_INST per lane, S cleared, stall_cnt=0.
- Lane masking:
  - On load, any lane whose in_lane bit is 0 stores BUBBLE_INST in its inst field; pc4 is stored unchanged.
  - A beat with in_lane=0 but in_valid=1 is still a legal beat and is passed through as an all-bubble beat.
- Payload rules:
  - Payload registers load only on the transitions listed above; otherwise they hold.
  - When out_valid=0 the payload is don't-care, but it must not toggle except on load, flush or reset.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at all-ones (no wrap). Cleared only by clr.
- Upstream rule: in_valid with data held stable until accept; the stage does not rely on this but the bench checks it.

Decomposition:
- Shared pipeline package:
  - XLEN default.
  - NOP encoding constant used for BUBBLE_INST.
  - Lane-packing helper (lane i occupies bits [i*XLEN +: XLEN]).
- One natural sub-module, pipe_beat_reg: a payload+valid register with load, clear and bubble-mask logic. It is instantiated twice (main and skid).
- State, handshake and counter logic stay in the top module.

Test Plan:
- Reset: clr=1 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_inst=BUBBLE_INST, stall_cnt=0.
- Streaming: LANES=2; 8 beats inst=32'h1000_0000+n, out_ready=1 throughout -> out_valid at cycle n+1, data in order, in_ready never drops, stall_cnt=0.
- Backpressure:
  - Send beats A,B; hold out_ready=0 after A arrives -> state FULL, in_ready=0, C held off.
  - Release out_ready -> A, B, C delivered in order with no loss.
  - stall_cnt equals the number of held cycles.
- Flush in FULL with in_valid=1 and beat D -> next cycle out_valid=0, in_ready=1, out_lane=0, D never appears.
- Lane mask: in_lane=2'b01, in_inst={32'hDEAD_BEEF, 32'h0000_0013} -> out_inst lane1=BUBBLE_INST, lane0=32'h0000_0013, out_lane=2'b01.
- Saturation: CNT_W=4; hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 4'hF. Then clr=1 with flush=1 in the same cycle -> stall_cnt=0 and outputs take their reset values.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: default widths, the NOP used for empty slots,
// the skid-stage occupancy encoding and the lane-packing helper.
package pipe_stage_skid_pkg;

    localparam int          XLEN_DEF = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Encoded as {skid valid, main valid}; skid-only is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_BUSY    = 2'b01,
        ST_ILLEGAL = 2'b10,
        ST_FULL    = 2'b11
    } skid_state_e;

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned xlen);
        return lane * xlen;
    endfunction

endpackage

// File: rtl/pipe_beat_reg.sv
// One beat of payload (lane mask, pc4, inst per lane) plus its valid bit.
// Lanes whose mask bit is clear are stored as the bubble instruction.
module pipe_beat_reg
    import pipe_stage_skid_pkg::*;
#(
    parameter int               XLEN        = XLEN_DEF,
    parameter int               LANES       = 1,
    parameter logic [XLEN-1:0]  BUBBLE_INST = NOP_INST
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   load,
    input  logic                   valid_nxt,
    input  logic [LANES-1:0]       in_lane,
    input  logic [LANES*XLEN-1:0]  in_pc4,
    input  logic [LANES*XLEN-1:0]  in_inst,
    output logic                   valid_q,
    output logic [LANES-1:0]       lane_q,
    output logic [LANES*XLEN-1:0]  pc4_q,
    output logic [LANES*XLEN-1:0]  inst_q
);

    logic [LANES*XLEN-1:0] inst_masked;
    logic                  valid_d;
    logic [LANES-1:0]      lane_d;
    logic [LANES*XLEN-1:0] pc4_d;
    logic [LANES*XLEN-1:0] inst_d;

    for (genvar i = 0; i < LANES; i++) begin : g_mask
        localparam int unsigned LSB = lane_lsb(i, XLEN);
        assign inst_masked[LSB +: XLEN] = in_lane[i] ? in_inst[LSB +: XLEN] : BUBBLE_INST;
    end

    always_comb begin
        valid_d = valid_nxt;
        lane_d  = lane_q;
        pc4_d   = pc4_q;
        inst_d  = inst_q;
        if (load) begin
            lane_d = in_lane;
            pc4_d  = in_pc4;
            inst_d = inst_masked;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= 1'b0;
            lane_q  <= '0;
            pc4_q   <= '0;
            inst_q  <= {LANES{BUBBLE_INST}};
        end else begin
            valid_q <= valid_d;
            lane_q  <= lane_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic multi-lane pipeline register with a one-entry skid buffer so that
// in_ready comes straight from a flop, plus flush and a stall-cycle counter.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int               XLEN        = XLEN_DEF,
    parameter int               LANES       = 1,
    parameter logic [XLEN-1:0]  BUBBLE_INST = NOP_INST,
    parameter int               CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_lane,
    input  logic [LANES*XLEN-1:0]  in_pc4,
    input  logic [LANES*XLEN-1:0]  in_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_lane,
    output logic [LANES*XLEN-1:0]  out_pc4,
    output logic [LANES*XLEN-1:0]  out_inst,
    output logic [CNT_W-1:0]       stall_cnt
);

    logic                  m_vld, s_vld;
    logic [LANES-1:0]      s_lane;
    logic [LANES*XLEN-1:0] s_pc4, s_inst;

    logic                  m_load, m_from_s, s_load;
    logic                  m_vld_d, s_vld_d;
    logic [LANES-1:0]      m_src_lane;
    logic [LANES*XLEN-1:0] m_src_pc4, m_src_inst;

    logic                  in_ready_q, in_ready_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic                  clear, accept, drain;
    skid_state_e           state;

    assign clear     = clr | flush;
    assign accept    = in_valid & in_ready_q;
    assign drain     = m_vld & out_ready;
    assign state     = skid_state_e'({s_vld, m_vld});
    assign in_ready  = in_ready_q;
    assign out_valid = m_vld;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        m_load   = 1'b0;
        m_from_s = 1'b0;
        s_load   = 1'b0;
        m_vld_d  = m_vld;
        s_vld_d  = s_vld;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    m_load  = 1'b1;
                    m_vld_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (accept && drain) begin
                    m_load = 1'b1;
                end else if (accept) begin
                    s_load  = 1'b1;
                    s_vld_d = 1'b1;
                end else if (drain) begin
                    m_vld_d = 1'b0;
                end
            end
            ST_FULL: begin
                // Upstream is held off; only the skid beat can move forward.
                if (drain) begin
                    m_load   = 1'b1;
                    m_from_s = 1'b1;
                    s_vld_d  = 1'b0;
                end
            end
            default: begin
                m_vld_d = 1'b0;
                s_vld_d = 1'b0;
            end
        endcase
    end

    assign m_src_lane = m_from_s ? s_lane : in_lane;
    assign m_src_pc4  = m_from_s ? s_pc4  : in_pc4;
    assign m_src_inst = m_from_s ? s_inst : in_inst;

    always_comb begin
        in_ready_d  = flush ? 1'b1 : !s_vld_d;
        stall_cnt_d = stall_cnt_q;
        if (m_vld && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    pipe_beat_reg #(
        .XLEN        (XLEN),
        .LANES       (LANES),
        .BUBBLE_INST (BUBBLE_INST)
    ) u_main (
        .clk       (clk),
        .clear     (clear),
        .load      (m_load),
        .valid_nxt (m_vld_d),
        .in_lane   (m_src_lane),
        .in_pc4    (m_src_pc4),
        .in_inst   (m_src_inst),
        .valid_q   (m_vld),
        .lane_q    (out_lane),
        .pc4_q     (out_pc4),
        .inst_q    (out_inst)
    );

    pipe_beat_reg #(
        .XLEN        (XLEN),
        .LANES       (LANES),
        .BUBBLE_INST (BUBBLE_INST)
    ) u_skid (
        .clk       (clk),
        .clear     (clear),
        .load      (s_load),
        .valid_nxt (s_vld_d),
        .in_lane   (in_lane),
        .in_pc4    (in_pc4),
        .in_inst   (in_inst),
        .valid_q   (s_vld),
        .lane_q    (s_lane),
        .pc4_q     (s_pc4),
        .inst_q    (s_inst)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: two lanes, 4-bit stall counter and a
// non-zero bubble encoding so bubbles are distinguishable from cleared data.
module tb_pipe_stage_skid;

    localparam int          XLEN  = 32;
    localparam int          LANES = 2;
    localparam int          CNT_W = 4;
    localparam logic [31:0] BUB   = 32'h0000_0013;

    logic                  clk = 1'b0;
    logic                  clr, flush, in_valid, in_ready, out_valid, out_ready;
    logic [LANES-1:0]      in_lane, out_lane;
    logic [LANES*XLEN-1:0] in_pc4, in_inst, out_pc4, out_inst;
    logic [CNT_W-1:0]      stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_skid #(
        .XLEN        (XLEN),
        .LANES       (LANES),
        .BUBBLE_INST (BUB),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lane   (in_lane),
        .in_pc4    (in_pc4),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lane  (out_lane),
        .out_pc4   (out_pc4),
        .out_inst  (out_inst),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_inst(input int n);
        return {32'h2000_0000 + n, 32'h1000_0000 + n};
    endfunction

    function automatic logic [63:0] beat_pc4(input int n);
        return {32'h0000_0104 + 8 * n, 32'h0000_0100 + 8 * n};
    endfunction

    task automatic drive(input logic v, input int n);
        in_valid = v;
        in_lane  = 2'b11;
        in_pc4   = beat_pc4(n);
        in_inst  = beat_inst(n);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_out_lane"},  64'(out_lane),  64'd0);
        chk({tag, "_out_pc4"},   out_pc4,        64'd0);
        chk({tag, "_out_inst"},  out_inst,       {BUB, BUB});
    endtask

    initial begin
        clr = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 99);

        // Reset held two cycles with a beat offered
        cyc();
        cyc();
        chk_reset_outputs("rst");
        chk("rst_stall", 64'(stall_cnt), 64'd0);

        // Streaming at full rate
        clr = 1'b0;
        for (int n = 0; n < 8; n++) begin
            drive(1'b1, n);
            cyc();
            chk($sformatf("str%0d_valid", n), 64'(out_valid), 64'd1);
            chk($sformatf("str%0d_inst", n),  out_inst, beat_inst(n));
            chk($sformatf("str%0d_pc4", n),   out_pc4,  beat_pc4(n));
            chk($sformatf("str%0d_ready", n), 64'(in_ready), 64'd1);
        end
        drive(1'b0, 0);
        cyc();
        chk("str_end_valid", 64'(out_valid), 64'd0);
        chk("str_stall", 64'(stall_cnt), 64'd0);

        // Backpressure: A, B fill the stage, C waits
        out_ready = 1'b0;
        drive(1'b1, 10);
        cyc();
        chk("bp_a_inst", out_inst, beat_inst(10));
        chk("bp_a_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 11);
        cyc();
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        chk("bp_full_inst", out_inst, beat_inst(10));
        chk("bp_stall1", 64'(stall_cnt), 64'd1);
        drive(1'b1, 12);
        cyc();
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_inst", out_inst, beat_inst(10));
        chk("bp_stall2", 64'(stall_cnt), 64'd2);
        cyc();
        chk("bp_stall3", 64'(stall_cnt), 64'd3);
        out_ready = 1'b1;
        cyc();
        chk("bp_b_inst", out_inst, beat_inst(11));
        chk("bp_b_pc4", out_pc4, beat_pc4(11));
        chk("bp_b_ready", 64'(in_ready), 64'd1);
        cyc();
        chk("bp_c_inst", out_inst, beat_inst(12));
        chk("bp_c_valid", 64'(out_valid), 64'd1);
        drive(1'b0, 0);
        cyc();
        chk("bp_end_valid", 64'(out_valid), 64'd0);
        chk("bp_stall_total", 64'(stall_cnt), 64'd3);

        // Flush while FULL with beat D offered
        out_ready = 1'b0;
        drive(1'b1, 20);
        cyc();
        drive(1'b1, 21);
        cyc();
        chk("fl_full_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 22);
        cyc();
        chk_reset_outputs("fl");
        chk("fl_stall", 64'(stall_cnt), 64'd5);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 0);
        cyc();
        chk("fl_no_d", 64'(out_valid), 64'd0);

        // Lane masking
        in_valid = 1'b1;
        in_lane  = 2'b01;
        in_pc4   = {32'h0000_0204, 32'h0000_0200};
        in_inst  = {32'hDEAD_BEEF, 32'h0000_0013};
        cyc();
        chk("lm01_inst", out_inst, {BUB, 32'h0000_0013});
        chk("lm01_lane", 64'(out_lane), 64'd1);
        chk("lm01_pc4", out_pc4, {32'h0000_0204, 32'h0000_0200});
        in_lane = 2'b10;
        in_inst = {32'hAAAA_0001, 32'hBBBB_0002};
        cyc();
        chk("lm10_inst", out_inst, {32'hAAAA_0001, BUB});
        chk("lm10_lane", 64'(out_lane), 64'd2);
        in_lane = 2'b00;
        cyc();
        chk("lm00_valid", 64'(out_valid), 64'd1);
        chk("lm00_inst", out_inst, {BUB, BUB});
        drive(1'b0, 0);
        cyc();

        // Counter saturation, then reset together with flush
        out_ready = 1'b0;
        drive(1'b1, 30);
        cyc();
        drive(1'b0, 0);
        chk("sat_start", 64'(stall_cnt), 64'd5);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == 9) chk("sat_mid", 64'(stall_cnt), 64'd14);
        end
        chk("sat_top", 64'(stall_cnt), 64'hF);
        chk("sat_valid", 64'(out_valid), 64'd1);
        chk("sat_inst", out_inst, beat_inst(30));
        clr = 1'b1;
        flush = 1'b1;
        drive(1'b1, 31);
        cyc();
        chk_reset_outputs("clrfl");
        chk("clrfl_stall", 64'(stall_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
